// File: rtl/acc_bank_if.sv
// acc_bank_if: write/operate port and both read ports of the accumulator bank.
//   master : drives we/op/waddr/din/raddr_a/raddr_b, receives rdata_a/rdata_b/carry/zero
//   slave  : the accumulator bank side
interface acc_bank_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
);
  logic             we;
  logic [2:0]       op;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] din;
  logic [AW-1:0]    raddr_a;
  logic [AW-1:0]    raddr_b;
  logic [WIDTH-1:0] rdata_a;
  logic [WIDTH-1:0] rdata_b;
  logic             carry;
  logic             zero;

  modport master (
    output we, op, waddr, din, raddr_a, raddr_b,
    input  rdata_a, rdata_b, carry, zero
  );

  modport slave (
    input  we, op, waddr, din, raddr_a, raddr_b,
    output rdata_a, rdata_b, carry, zero
  );
endinterface

// File: rtl/acc_bank.sv
// acc_bank: NREGS independent WIDTH-bit accumulators with one write/operate
// port and two combinational read ports. Each executed op updates the
// addressed register plus the global carry and zero flags.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset, clears registers and flags
//   bus  : acc_bank_if slave (we, op, waddr, din, raddr_a/b -> rdata_a/b, carry, zero)
// BYPASS=1 forwards the result being written this cycle to a read port
// that addresses the same register.
module acc_bank #(
  parameter int WIDTH  = 8,
  parameter int NREGS  = 4,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic       clk,
  input  logic       rst,
  acc_bank_if.slave  bus
);

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_CLR  = 3'b001;
  localparam logic [2:0] OP_INC  = 3'b010;
  localparam logic [2:0] OP_DEC  = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_ADD  = 3'b110;
  localparam logic [2:0] OP_SUB  = 3'b111;

  localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] res;
  logic             res_c;
  logic             wvalid;
  logic             carry_q;
  logic             zero_q;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;

  // Addresses past NREGS only exist when NREGS is not a power of two.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return {1'b0, a} < NREGS_W;
  endfunction

  assign wvalid = bus.we && addr_ok(bus.waddr);
  assign cur    = addr_ok(bus.waddr) ? regs[bus.waddr] : '0;

  // Carry/borrow falls out of the extra top bit of a WIDTH+1 wide add/sub.
  always_comb begin
    res   = '0;
    res_c = 1'b0;
    case (bus.op)
      OP_LOAD: res = bus.din;
      OP_CLR:  res = '0;
      OP_INC:  {res_c, res} = {1'b0, cur} + (WIDTH+1)'(1);
      OP_DEC:  {res_c, res} = {1'b0, cur} - (WIDTH+1)'(1);
      OP_SHL: begin
        res   = {cur[WIDTH-2:0], 1'b0};
        res_c = cur[WIDTH-1];
      end
      OP_SHR: begin
        res   = {1'b0, cur[WIDTH-1:1]};
        res_c = cur[0];
      end
      OP_ADD:  {res_c, res} = {1'b0, cur} + {1'b0, bus.din};
      OP_SUB:  {res_c, res} = {1'b0, cur} - {1'b0, bus.din};
      default: begin
        res   = '0;
        res_c = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else if (wvalid) begin
      regs[bus.waddr] <= res;
      carry_q         <= res_c;
      zero_q          <= (res == '0);
    end
  end

  // Reads are gated by rst so the ports show 0 for the whole reset pulse.
  always_comb begin
    rd_a = '0;
    if (!rst) begin
      if (BYPASS != 0 && wvalid && bus.raddr_a == bus.waddr) rd_a = res;
      else if (addr_ok(bus.raddr_a))                        rd_a = regs[bus.raddr_a];
    end
  end

  always_comb begin
    rd_b = '0;
    if (!rst) begin
      if (BYPASS != 0 && wvalid && bus.raddr_b == bus.waddr) rd_b = res;
      else if (addr_ok(bus.raddr_b))                        rd_b = regs[bus.raddr_b];
    end
  end

  assign bus.rdata_a = rd_a;
  assign bus.rdata_b = rd_b;
  assign bus.carry   = carry_q;
  assign bus.zero    = zero_q;

endmodule

// File: tb/tb_acc_bank.sv
// Bench for acc_bank: three instances share one stimulus stream
//   dut_bp : NREGS=4, BYPASS=1
//   dut_nb : NREGS=4, BYPASS=0
//   dut_n3 : NREGS=3, BYPASS=1
// A behavioural model of each instance is compared on every falling edge,
// and directed literal checks pin the model at the interesting points.
module tb_acc_bank;

  localparam int NDUT = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       we;
  logic [2:0] op;
  logic [1:0] waddr;
  logic [7:0] din;
  logic [1:0] raddr_a;
  logic [1:0] raddr_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  acc_bank_if #(.WIDTH(8), .AW(2)) bus0 ();
  acc_bank_if #(.WIDTH(8), .AW(2)) bus1 ();
  acc_bank_if #(.WIDTH(8), .AW(2)) bus2 ();

  assign bus0.we = we;  assign bus0.op = op;  assign bus0.waddr = waddr;  assign bus0.din = din;
  assign bus0.raddr_a = raddr_a;  assign bus0.raddr_b = raddr_b;
  assign bus1.we = we;  assign bus1.op = op;  assign bus1.waddr = waddr;  assign bus1.din = din;
  assign bus1.raddr_a = raddr_a;  assign bus1.raddr_b = raddr_b;
  assign bus2.we = we;  assign bus2.op = op;  assign bus2.waddr = waddr;  assign bus2.din = din;
  assign bus2.raddr_a = raddr_a;  assign bus2.raddr_b = raddr_b;

  acc_bank #(.WIDTH(8), .NREGS(4), .BYPASS(1)) dut_bp (.clk(clk), .rst(rst), .bus(bus0));
  acc_bank #(.WIDTH(8), .NREGS(4), .BYPASS(0)) dut_nb (.clk(clk), .rst(rst), .bus(bus1));
  acc_bank #(.WIDTH(8), .NREGS(3), .BYPASS(1)) dut_n3 (.clk(clk), .rst(rst), .bus(bus2));

  logic [7:0] ra [NDUT];
  logic [7:0] rb [NDUT];
  logic       cf [NDUT];
  logic       zf [NDUT];

  assign ra[0] = bus0.rdata_a;  assign rb[0] = bus0.rdata_b;  assign cf[0] = bus0.carry;  assign zf[0] = bus0.zero;
  assign ra[1] = bus1.rdata_a;  assign rb[1] = bus1.rdata_b;  assign cf[1] = bus1.carry;  assign zf[1] = bus1.zero;
  assign ra[2] = bus2.rdata_a;  assign rb[2] = bus2.rdata_b;  assign cf[2] = bus2.carry;  assign zf[2] = bus2.zero;

  // ---------------- behavioural model ----------------
  int m_regs [NDUT][4];
  int m_c    [NDUT];
  int m_z    [NDUT];

  function automatic int nregs_of(input int i);
    return (i == 2) ? 3 : 4;
  endfunction

  function automatic bit bypass_of(input int i);
    return (i != 1);
  endfunction

  // Plain unsigned arithmetic on 0..255 values.
  function automatic void model_op(input int r, input int o, input int d,
                                   output int res, output int c);
    case (o)
      0: begin res = d;                 c = 0; end
      1: begin res = 0;                 c = 0; end
      2: begin res = (r + 1) % 256;     c = (r == 255) ? 1 : 0; end
      3: begin res = (r + 255) % 256;   c = (r == 0) ? 1 : 0; end
      4: begin res = (r * 2) % 256;     c = (r >= 128) ? 1 : 0; end
      5: begin res = r / 2;             c = r % 2; end
      6: begin res = (r + d) % 256;     c = (r + d > 255) ? 1 : 0; end
      default: begin res = (r - d + 256) % 256; c = (d > r) ? 1 : 0; end
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    int res, c;
    if (rst) begin
      for (int i = 0; i < NDUT; i++) begin
        for (int j = 0; j < 4; j++) m_regs[i][j] = 0;
        m_c[i] = 0;
        m_z[i] = 0;
      end
    end else if (we) begin
      for (int i = 0; i < NDUT; i++) begin
        if (int'(waddr) < nregs_of(i)) begin
          model_op(m_regs[i][waddr], int'(op), int'(din), res, c);
          m_regs[i][waddr] = res;
          m_c[i] = c;
          m_z[i] = (res == 0) ? 1 : 0;
        end
      end
    end
  end

  function automatic int exp_read(input int i, input int a);
    int res, c;
    if (rst) return 0;
    if (bypass_of(i) && we && int'(waddr) < nregs_of(i) && a == int'(waddr)) begin
      model_op(m_regs[i][a], int'(op), int'(din), res, c);
      return res;
    end
    if (a < nregs_of(i)) return m_regs[i][a];
    return 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("dut%0d rdata_a", i), 32'(ra[i]), 32'(exp_read(i, int'(raddr_a))));
      check($sformatf("dut%0d rdata_b", i), 32'(rb[i]), 32'(exp_read(i, int'(raddr_b))));
      check($sformatf("dut%0d carry", i),   32'(cf[i]), 32'(m_c[i]));
      check($sformatf("dut%0d zero", i),    32'(zf[i]), 32'(m_z[i]));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input int o, input int a, input int d);
    we    = 1'b1;
    op    = o[2:0];
    waddr = a[1:0];
    din   = d[7:0];
    sync();
    we    = 1'b0;
  endtask

  task automatic peek(input int k, input int a, input int exp, input string name);
    raddr_a = a[1:0];
    raddr_b = a[1:0];
    #1;
    check({name, " port_a"}, 32'(ra[k]), 32'(exp));
    check({name, " port_b"}, 32'(rb[k]), 32'(exp));
  endtask

  task automatic flags(input int k, input int c, input int z, input string name);
    check({name, " carry"}, 32'(cf[k]), 32'(c));
    check({name, " zero"},  32'(zf[k]), 32'(z));
  endtask

  initial begin
    rst = 1'b0; we = 1'b0; op = 3'd0; waddr = 2'd0; din = 8'd0;
    raddr_a = 2'd0; raddr_b = 2'd0;
    #1 rst = 1'b1;
    sync();
    sync();
    rst = 1'b0;
    flags(0, 0, 0, "after_reset");
    peek(0, 2, 8'h00, "after_reset r2");
    sync();

    // reset mid-run
    do_op(0, 0, 8'h11);
    do_op(0, 1, 8'h22);
    do_op(0, 2, 8'h33);
    do_op(0, 3, 8'h44);
    peek(0, 1, 8'h22, "load r1");
    sync();
    do_op(6, 3, 8'hBC);
    flags(0, 1, 1, "add wrap to zero");
    peek(0, 3, 8'h00, "add wrap r3");
    sync();
    rst = 1'b1;
    raddr_a = 2'd0; raddr_b = 2'd1;
    #1;
    check("rst r0", 32'(ra[0]), 32'h00);
    check("rst r1", 32'(rb[0]), 32'h00);
    flags(0, 0, 0, "rst async");
    raddr_a = 2'd2; raddr_b = 2'd3;
    #1;
    check("rst r2", 32'(ra[0]), 32'h00);
    check("rst r3", 32'(rb[1]), 32'h00);
    we = 1'b1; op = 3'd0; waddr = 2'd0; din = 8'h99;
    sync();
    we = 1'b0;
    rst = 1'b0;
    peek(0, 0, 8'h00, "rst beats we");
    sync();

    // wrap
    do_op(0, 1, 8'hFF);
    do_op(2, 1, 0);
    peek(0, 1, 8'h00, "inc wrap");
    flags(0, 1, 1, "inc wrap");
    do_op(3, 1, 0);
    peek(0, 1, 8'hFF, "dec wrap");
    flags(0, 1, 0, "dec wrap");

    // arithmetic
    do_op(0, 2, 8'hF0);
    do_op(6, 2, 8'h20);
    peek(0, 2, 8'h10, "add carry");
    flags(0, 1, 0, "add carry");
    do_op(7, 2, 8'h11);
    peek(0, 2, 8'hFF, "sub borrow");
    flags(0, 1, 0, "sub borrow");
    do_op(7, 2, 8'h0F);
    peek(0, 2, 8'hF0, "sub no borrow");
    flags(0, 0, 0, "sub no borrow");

    // shifts (r3 does not exist in dut_n3)
    do_op(0, 3, 8'h81);
    do_op(4, 3, 0);
    peek(0, 3, 8'h02, "shl");
    flags(0, 1, 0, "shl");
    do_op(5, 3, 0);
    peek(0, 3, 8'h01, "shr");
    flags(0, 0, 0, "shr");
    do_op(5, 3, 0);
    peek(0, 3, 8'h00, "shr to zero");
    flags(0, 1, 1, "shr to zero");

    // bypass vs no bypass
    do_op(0, 0, 8'h5A);
    raddr_a = 2'd0; raddr_b = 2'd0;
    we = 1'b1; op = 3'd2; waddr = 2'd0; din = 8'h00;
    #1;
    check("bypass a", 32'(ra[0]), 32'h5B);
    check("bypass b", 32'(rb[0]), 32'h5B);
    check("nobypass a", 32'(ra[1]), 32'h5A);
    check("nobypass b", 32'(rb[1]), 32'h5A);
    sync();
    we = 1'b0;
    peek(1, 0, 8'h5B, "nobypass after edge");
    sync();

    // hold and invalid address on the NREGS=3 instance
    do_op(7, 2, 8'hF1);
    peek(2, 2, 8'hFF, "n3 sub");
    flags(2, 1, 0, "n3 sub");
    we = 1'b0; op = 3'd1; waddr = 2'd2;
    sync();
    peek(2, 2, 8'hFF, "we0 clr hold");
    flags(2, 1, 0, "we0 clr hold");
    sync();
    raddr_a = 2'd3; raddr_b = 2'd3;
    we = 1'b1; op = 3'd0; waddr = 2'd3; din = 8'h77;
    #1;
    check("n3 invalid bypass", 32'(ra[2]), 32'h00);
    check("bp valid bypass",   32'(ra[0]), 32'h77);
    sync();
    we = 1'b0;
    peek(2, 3, 8'h00, "n3 read r3");
    flags(2, 1, 0, "n3 invalid hold");
    peek(2, 0, 8'h5B, "n3 r0 kept");
    peek(2, 1, 8'hFF, "n3 r1 kept");
    sync();
    peek(2, 2, 8'hFF, "n3 r2 kept");
    peek(0, 3, 8'h77, "bp r3 load");
    sync();
    sync();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/acc_bank.md
# acc_bank

Parametrised accumulator bank for the RISC CPU datapath: NREGS independent WIDTH-bit accumulators sharing one write/operate port and two combinational read ports. Each write performs one of eight ALU-lite operations (load, clear, inc, dec, shift, add, sub) on the addressed register, and updates carry and zero flags. It is the successor to the single 8-bit accumulator: the default configuration (WIDTH=8, op=LOAD) reproduces the plain load behaviour.

## Interface
- WIDTH, 8, data width of every register; must be ≥ 2
- NREGS, 4, number of registers; must be ≥ 2; AW = $clog2(NREGS)
- BYPASS, 1, 1 = write-to-read forwarding on both read ports; 0 = no forwarding
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous, active-high; clears all registers and flags
- we  input  1  execute `op` on register `waddr` this cycle
- op  input  3  operation select (see Operation)
- waddr  input  AW  target register
- din  input  WIDTH  operand for LOAD, ADD and SUB
- raddr_a  input  AW  read port A address
- raddr_b  input  AW  read port B address
- rdata_a  output  WIDTH  port A data (combinational)
- rdata_b  output  WIDTH  port B data (combinational)
- carry  output  1  registered carry/borrow flag from the last executed op
- zero  output  1  registered flag; 1 when the last executed op's result was 0

## Operation
- Op encoding (R = current value of regs[waddr]; result written back to regs[waddr]):
  - 000 LOAD: din; carry = 0
  - 001 CLR: 0; carry = 0
  - 010 INC: R+1; carry = 1 on wrap from all-ones to 0
  - 011 DEC: R−1; carry = 1 (borrow) on wrap from 0 to all-ones
  - 100 SHL: {R[WIDTH-2:0],0}; carry = R[WIDTH-1]
  - 101 SHR: {0,R[WIDTH-1:1]}; carry = R[0]
  - 110 ADD: R+din, truncated to WIDTH; carry = bit WIDTH of the (WIDTH+1)-bit sum
  - 111 SUB: R−din, truncated to WIDTH; carry = 1 when din > R (unsigned borrow)
- zero = (result == 0), for every op.
- Flags are global, not per register. They update only when an op executes, and hold otherwise.
- we=0: no register or flag changes.
- waddr ≥ NREGS (non-power-of-2 NREGS): the write is ignored and the flags hold.
- Read ports: rdata_x = regs[raddr_x]. A read with raddr_x ≥ NREGS returns 0.
- BYPASS=1: if we=1, waddr is valid and raddr_x == waddr, rdata_x returns this cycle's result, not the stored value. This applies to both ports independently.
- Both ports may address the same register. Both then return the same value.

## Timing
- Reset: asserting rst forces every register, carry and zero to 0 immediately, without waiting for a clock edge. While rst is high, the rdata outputs return 0.
- Reset takes priority over we. Deasserting rst takes effect at the next rising edge; the first op can execute on that edge.
- Write latency is 1 cycle: the result is visible in the register and flags after the rising edge on which we=1 is sampled.
- Read latency is 0 cycles (combinational). With BYPASS=0, a same-address read returns the old value until the edge.
- Back-to-back ops on the same register chain: each cycle's op uses the value written on the previous edge.
- Only one write per cycle is possible, so there are no write-write conflicts.
- There is no combinational path from inputs to carry or zero.

## Test plan
- Reset mid-run: load regs 0..3 with 0x11,0x22,0x33,0x44, then pulse rst between clock edges -> all rdata=0x00, carry=0 and zero=0 immediately, before the next edge.
- Wrap: LOAD r1=0xFF, then INC r1 -> r1=0x00, carry=1, zero=1. Then DEC r1 -> r1=0xFF, carry=1, zero=0.
- Arithmetic: LOAD r2=0xF0, then ADD din=0x20 -> r2=0x10, carry=1. Then SUB din=0x11 -> r2=0xFF, carry=1. Then SUB din=0x0F -> r2=0xF0, carry=0.
- Shifts: LOAD r3=0x81, then SHL -> 0x02 with carry=1. Then SHR -> 0x01 with carry=0. Then SHR -> 0x00 with carry=1 and zero=1.
- Bypass, BYPASS=1: LOAD r0=0x5A, then raddr_a=raddr_b=0 with we=1 and INC -> both ports show 0x5B in the same cycle. With BYPASS=0 the ports show 0x5A, and 0x5B after the edge.
- Hold/invalid, NREGS=3: with we=0 apply op=CLR -> no change. With we=1 and waddr=3 apply LOAD 0x77 -> no register changes, flags hold, and raddr=3 reads 0.
